pbuf6_prog_ctrl: RTL and testbench



---
 rtl/pbuf6_prog_ctrl_if.sv | 26 ++
 rtl/pbuf6_prog_ctrl.sv | 156 +++++++++++++++
 tb/tb_pbuf6_prog_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbuf6_prog_ctrl_if.sv
// ---------------------------------------------------------------------------
// pbuf6_prog_ctrl_if
// Request channel from the chip configuration bus into pbuf6_prog_ctrl.
//   cfg_valid : a programming request is presented       (master -> slave)
//   cfg_ready : controller accepts the request this cycle (slave -> master)
//   cfg_word  : six buffer enables, bit i = q[i] of the target pbuf6
//   cfg_bank  : index of the target pbuf6 instance
// ---------------------------------------------------------------------------
interface pbuf6_prog_ctrl_if #(
   parameter int BANK_W = 1
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [5:0]        cfg_word;
   logic [BANK_W-1:0] cfg_bank;

   modport master (
      output cfg_valid, cfg_word, cfg_bank,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_word, cfg_bank,
      output cfg_ready
   );
endinterface

// File: rtl/pbuf6_prog_ctrl.sv
// ---------------------------------------------------------------------------
// pbuf6_prog_ctrl
// Sequences the configuration storage of NUM_BANKS pbuf6 tristate-buffer
// arrays. A 6-bit enable word is written as two columns: column 0 carries
// word[2:0], column 1 carries word[5:3], each through a SETUP / PULSE / HOLD
// phase with programmable lengths.
//
// Ports
//   clk, rst             : single clock, synchronous active-high reset
//   cfg (slave)          : valid/ready request with cfg_word and cfg_bank
//   busy                 : a programming sequence is in progress
//   done                 : one-cycle pulse when a sequence completes
//   err                  : one-cycle pulse when a request names an illegal bank
//   prog_dat0..2         : shared row data to every pbuf6
//   prog_cap0/prog_cap1  : per-bank column capture strobes
// ---------------------------------------------------------------------------
module pbuf6_prog_ctrl #(
   parameter int NUM_BANKS = 1,
   parameter int BANK_W    = 1,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   pbuf6_prog_ctrl_if.slave     cfg,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 prog_dat0,
   output logic                 prog_dat1,
   output logic                 prog_dat2,
   output logic [NUM_BANKS-1:0] prog_cap0,
   output logic [NUM_BANKS-1:0] prog_cap1
);

   if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
       HOLD_CYC < 1 || HOLD_CYC > 15 || NUM_BANKS < 1 ||
       (2 ** BANK_W) < NUM_BANKS) begin : g_bad_param
      $error("pbuf6_prog_ctrl: illegal parameter value");
   end

   // Phase counters load length-1 and the phase ends when they reach zero.
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

   state_t                 state;
   logic [3:0]             cnt;
   logic                   col;
   logic [2:0]             col1_bits;   // {dat0,dat1,dat2} for column 1
   logic [NUM_BANKS-1:0]   bank_oh_q;
   logic [NUM_BANKS-1:0]   bank_oh;
   logic                   bank_ok;

   // Decode the requested bank to one-hot; an out-of-range index yields
   // bank_ok = 0 rather than a wide compare against NUM_BANKS.
   always_comb begin
      bank_oh = '0;
      bank_ok = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (int'(cfg.cfg_bank) == b) begin
            bank_oh[b] = 1'b1;
            bank_ok    = 1'b1;
         end
      end
   end

   assign cfg.cfg_ready = (state == IDLE);

   // Outputs are registered and change together with the state they belong
   // to, so dat only moves on SETUP entry and cap only toggles on PULSE
   // entry/exit -- never both on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         col       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         prog_dat0 <= 1'b0;
         prog_dat1 <= 1'b0;
         prog_dat2 <= 1'b0;
         prog_cap0 <= '0;
         prog_cap1 <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg.cfg_valid) begin
                  if (!bank_ok) begin
                     err <= 1'b1;
                  end else begin
                     bank_oh_q <= bank_oh;
                     col1_bits <= {cfg.cfg_word[3], cfg.cfg_word[4], cfg.cfg_word[5]};
                     prog_dat0 <= cfg.cfg_word[0];
                     prog_dat1 <= cfg.cfg_word[1];
                     prog_dat2 <= cfg.cfg_word[2];
                     col       <= 1'b0;
                     cnt       <= SETUP_LD;
                     busy      <= 1'b1;
                     state     <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (cnt == 4'd0) begin
                  if (col) prog_cap1 <= bank_oh_q;
                  else     prog_cap0 <= bank_oh_q;
                  cnt   <= PULSE_LD;
                  state <= PULSE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            PULSE: begin
               if (cnt == 4'd0) begin
                  prog_cap0 <= '0;
                  prog_cap1 <= '0;
                  cnt       <= HOLD_LD;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: begin
               if (cnt == 4'd0) begin
                  if (!col) begin
                     col       <= 1'b1;
                     prog_dat0 <= col1_bits[2];
                     prog_dat1 <= col1_bits[1];
                     prog_dat2 <= col1_bits[0];
                     cnt       <= SETUP_LD;
                     state     <= SETUP;
                  end else begin
                     prog_dat0 <= 1'b0;
                     prog_dat1 <= 1'b0;
                     prog_dat2 <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pbuf6_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pbuf6_prog_ctrl
// Three controller instances sharing clk/rst:
//   u_a : defaults (1 bank, 1/2/1 timing)
//   u_b : 3 banks, BANK_W = 2, default timing
//   u_c : 1 bank, SETUP=3 PULSE=1 HOLD=4
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, so each sample shows the state left by the
// edge just taken.
// ---------------------------------------------------------------------------
module tb_pbuf6_prog_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   pbuf6_prog_ctrl_if #(.BANK_W(1)) if_a ();
   pbuf6_prog_ctrl_if #(.BANK_W(2)) if_b ();
   pbuf6_prog_ctrl_if #(.BANK_W(1)) if_c ();

   logic       busy_a, done_a, err_a, dat0_a, dat1_a, dat2_a;
   logic [0:0] cap0_a, cap1_a;
   logic       busy_b, done_b, err_b, dat0_b, dat1_b, dat2_b;
   logic [2:0] cap0_b, cap1_b;
   logic       busy_c, done_c, err_c, dat0_c, dat1_c, dat2_c;
   logic [0:0] cap0_c, cap1_c;

   pbuf6_prog_ctrl u_a (
      .clk(clk), .rst(rst), .cfg(if_a.slave),
      .busy(busy_a), .done(done_a), .err(err_a),
      .prog_dat0(dat0_a), .prog_dat1(dat1_a), .prog_dat2(dat2_a),
      .prog_cap0(cap0_a), .prog_cap1(cap1_a)
   );

   pbuf6_prog_ctrl #(.NUM_BANKS(3), .BANK_W(2)) u_b (
      .clk(clk), .rst(rst), .cfg(if_b.slave),
      .busy(busy_b), .done(done_b), .err(err_b),
      .prog_dat0(dat0_b), .prog_dat1(dat1_b), .prog_dat2(dat2_b),
      .prog_cap0(cap0_b), .prog_cap1(cap1_b)
   );

   pbuf6_prog_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) u_c (
      .clk(clk), .rst(rst), .cfg(if_c.slave),
      .busy(busy_c), .done(done_c), .err(err_c),
      .prog_dat0(dat0_c), .prog_dat1(dat1_c), .prog_dat2(dat2_c),
      .prog_cap0(cap0_c), .prog_cap1(cap1_c)
   );

   // {ready, busy, done, dat0, dat1, dat2, cap0, cap1}
   logic [7:0] vec_a, vec_c;
   assign vec_a = {if_a.cfg_ready, busy_a, done_a, dat0_a, dat1_a, dat2_a, cap0_a[0], cap1_a[0]};
   assign vec_c = {if_c.cfg_ready, busy_c, done_c, dat0_c, dat1_c, dat2_c, cap0_c[0], cap1_c[0]};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic seen;
      rst = 1'b1;
      if_a.cfg_valid = 1'b0; if_a.cfg_word = '0; if_a.cfg_bank = '0;
      if_b.cfg_valid = 1'b0; if_b.cfg_word = '0; if_b.cfg_bank = '0;
      if_c.cfg_valid = 1'b0; if_c.cfg_word = '0; if_c.cfg_bank = '0;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({vec_a, err_a} !== 9'b1000_0000_0) begin
         n_bad++; $display("FAIL reset_a: got %b expected %b", {vec_a, err_a}, 9'b1000_0000_0);
      end
      n_cmp++;
      if ({if_b.cfg_ready, busy_b, done_b, err_b, dat0_b, dat1_b, dat2_b, cap0_b, cap1_b} !== 13'b1000_000_000_000) begin
         n_bad++; $display("FAIL reset_b: got %b expected %b",
            {if_b.cfg_ready, busy_b, done_b, err_b, dat0_b, dat1_b, dat2_b, cap0_b, cap1_b}, 13'b1000_000_000_000);
      end
      n_cmp++;
      if ({vec_c, err_c} !== 9'b1000_0000_0) begin
         n_bad++; $display("FAIL reset_c: got %b expected %b", {vec_c, err_c}, 9'b1000_0000_0);
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cap0_a != 0 || cap1_a != 0 || cap0_b != 0 || cap1_b != 0 ||
             cap0_c != 0 || cap1_c != 0 || busy_a || busy_b || busy_c) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL idle_quiet: activity seen %b expected %b", seen, 1'b0);
      end
   endtask

   task automatic test_single_program();
      logic [7:0] exp_tab [10];
      // word 6'b101101: col0 dat = {w0,w1,w2} = 101, col1 dat = {w3,w4,w5} = 101
      exp_tab = '{8'b0_1_0_101_00, 8'b0_1_0_101_10, 8'b0_1_0_101_10, 8'b0_1_0_101_00,
                  8'b0_1_0_101_00, 8'b0_1_0_101_01, 8'b0_1_0_101_01, 8'b0_1_0_101_00,
                  8'b1_0_1_000_00, 8'b1_0_0_000_00};
      if_a.cfg_valid = 1'b1; if_a.cfg_word = 6'b101101; if_a.cfg_bank = 1'b0;
      tick();
      if_a.cfg_valid = 1'b0; if_a.cfg_word = 6'b000000;
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (vec_a !== exp_tab[k]) begin
            n_bad++; $display("FAIL single_cycle%0d: got %b expected %b", k + 1, vec_a, exp_tab[k]);
         end
         tick();
      end
   endtask

   task automatic test_input_change();
      int wait_cnt;
      if_a.cfg_valid = 1'b1; if_a.cfg_word = 6'h3F; if_a.cfg_bank = 1'b0;
      tick();
      if_a.cfg_word = 6'h00;                   // valid stays high
      for (int k = 1; k <= 8; k++) begin
         n_cmp++;
         if ({if_a.cfg_ready, busy_a} !== 2'b01) begin
            n_bad++; $display("FAIL chg_ready_busy_k%0d: got %b expected %b", k, {if_a.cfg_ready, busy_a}, 2'b01);
         end
         if (k == 2 || k == 6) begin
            n_cmp++;
            if ({dat0_a, dat1_a, dat2_a, cap0_a[0], cap1_a[0]} !== {3'b111, (k == 2), (k == 6)}) begin
               n_bad++; $display("FAIL chg_strobe_k%0d: got %b expected %b", k,
                  {dat0_a, dat1_a, dat2_a, cap0_a[0], cap1_a[0]}, {3'b111, (k == 2), (k == 6)});
            end
         end
         tick();
      end
      n_cmp++;
      if ({if_a.cfg_ready, busy_a, done_a} !== 3'b101) begin
         n_bad++; $display("FAIL chg_done_cycle: got %b expected %b", {if_a.cfg_ready, busy_a, done_a}, 3'b101);
      end
      tick();                                  // second request accepted on this edge
      if_a.cfg_valid = 1'b0;
      n_cmp++;
      if (vec_a !== 8'b0_1_0_000_00) begin
         n_bad++; $display("FAIL b2b_start: got %b expected %b", vec_a, 8'b0_1_0_000_00);
      end
      wait_cnt = 0;
      while (!done_a && wait_cnt < 20) begin
         tick();
         wait_cnt++;
      end
      n_cmp++;
      if (done_a !== 1'b1) begin
         n_bad++; $display("FAIL b2b_done_timeout: got %b expected %b", done_a, 1'b1);
      end
      n_cmp++;
      if (wait_cnt !== 8) begin
         n_bad++; $display("FAIL b2b_length: got %0d expected %0d", wait_cnt, 8);
      end
      tick();
   endtask

   task automatic test_multi_bank();
      logic [2:0] e_cap0, e_cap1;
      logic seen;
      // word 6'h21: col0 dat = 100, col1 dat = 001
      if_b.cfg_valid = 1'b1; if_b.cfg_word = 6'h21; if_b.cfg_bank = 2'd2;
      tick();
      if_b.cfg_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         e_cap0 = (k == 2 || k == 3) ? 3'b100 : 3'b000;
         e_cap1 = (k == 6 || k == 7) ? 3'b100 : 3'b000;
         n_cmp++;
         if ({cap0_b, cap1_b} !== {e_cap0, e_cap1}) begin
            n_bad++; $display("FAIL mb_caps_k%0d: got %b expected %b", k, {cap0_b, cap1_b}, {e_cap0, e_cap1});
         end
         if (k == 2 || k == 6) begin
            n_cmp++;
            if ({dat0_b, dat1_b, dat2_b} !== ((k == 2) ? 3'b100 : 3'b001)) begin
               n_bad++; $display("FAIL mb_dat_k%0d: got %b expected %b", k,
                  {dat0_b, dat1_b, dat2_b}, ((k == 2) ? 3'b100 : 3'b001));
            end
         end
         if (k == 9) begin
            n_cmp++;
            if ({done_b, busy_b} !== 2'b10) begin
               n_bad++; $display("FAIL mb_done: got %b expected %b", {done_b, busy_b}, 2'b10);
            end
         end
         tick();
      end
      // Illegal bank 3
      if_b.cfg_valid = 1'b1; if_b.cfg_word = 6'h3F; if_b.cfg_bank = 2'd3;
      tick();
      if_b.cfg_valid = 1'b0;
      n_cmp++;
      if ({err_b, if_b.cfg_ready, busy_b} !== 3'b110) begin
         n_bad++; $display("FAIL mb_err_pulse: got %b expected %b", {err_b, if_b.cfg_ready, busy_b}, 3'b110);
      end
      tick();
      n_cmp++;
      if ({err_b, if_b.cfg_ready} !== 2'b01) begin
         n_bad++; $display("FAIL mb_err_clear: got %b expected %b", {err_b, if_b.cfg_ready}, 2'b01);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (cap0_b != 0 || cap1_b != 0 || busy_b || !if_b.cfg_ready) seen = 1'b1;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL mb_err_quiet: activity seen %b expected %b", seen, 1'b0);
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic seen;
      if_a.cfg_valid = 1'b1; if_a.cfg_word = 6'h3F; if_a.cfg_bank = 1'b0;
      tick();
      if_a.cfg_valid = 1'b0;
      tick();
      n_cmp++;
      if (cap0_a[0] !== 1'b1) begin
         n_bad++; $display("FAIL rmp_in_pulse: got %b expected %b", cap0_a[0], 1'b1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (vec_a !== 8'b1000_0000) begin
         n_bad++; $display("FAIL rmp_cleared: got %b expected %b", vec_a, 8'b1000_0000);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_a || busy_a || cap0_a != 0 || cap1_a != 0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL rmp_no_done: activity seen %b expected %b", seen, 1'b0);
      end
   endtask

   task automatic test_timing_params();
      logic [7:0] exp_v;
      logic [2:0] prev_dat;
      logic       prev_cap;
      int         busy_cnt;
      int         off;
      // word 6'b110010: col0 dat = {w0,w1,w2} = 010, col1 dat = {w3,w4,w5} = 011
      if_c.cfg_valid = 1'b1; if_c.cfg_word = 6'b110010; if_c.cfg_bank = 1'b0;
      tick();
      if_c.cfg_valid = 1'b0;
      busy_cnt = 0;
      prev_cap = 1'b0;
      prev_dat = 3'b000;
      // Each column spans 3 setup + 1 pulse + 4 hold = 8 cycles.
      for (int k = 1; k <= 18; k++) begin
         if (k <= 16) begin
            off   = (k - 1) % 8;
            exp_v = {1'b0, 1'b1, 1'b0, (k <= 8) ? 3'b010 : 3'b011,
                     (k <= 8 && off == 3), (k > 8 && off == 3)};
         end else if (k == 17) begin
            exp_v = 8'b1_0_1_000_00;
         end else begin
            exp_v = 8'b1_0_0_000_00;
         end
         n_cmp++;
         if (vec_c !== exp_v) begin
            n_bad++; $display("FAIL tim_cycle%0d: got %b expected %b", k, vec_c, exp_v);
         end
         if (prev_cap) begin
            n_cmp++;
            if ({dat0_c, dat1_c, dat2_c} !== prev_dat) begin
               n_bad++; $display("FAIL tim_dat_stable_k%0d: got %b expected %b", k, {dat0_c, dat1_c, dat2_c}, prev_dat);
            end
         end
         if (busy_c) busy_cnt++;
         prev_cap = cap0_c[0] | cap1_c[0];
         prev_dat = {dat0_c, dat1_c, dat2_c};
         tick();
      end
      n_cmp++;
      if (busy_cnt !== 16) begin
         n_bad++; $display("FAIL tim_busy_len: got %0d expected %0d", busy_cnt, 16);
      end
   endtask

   initial begin
      test_reset();
      test_single_program();
      test_input_change();
      test_multi_bank();
      test_reset_mid_pulse();
      test_timing_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
